// File: rtl/keypad_bcd_ctrl.sv
// rtl/keypad_bcd_ctrl.sv - debounced 10-key keypad to BCD digit events with valid/ready handoff
// Optional build macro: KEY_AUTOREPEAT_EN (auto-repeat while a key stays held)
module keypad_bcd_ctrl #(
`ifdef KEY_AUTOREPEAT_EN
    parameter int REPEAT_DELAY    = 2000,
    parameter int REPEAT_PERIOD   = 500,
`endif
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] key_n,
    output logic [3:0] digit_bcd,
    output logic       digit_valid,
    input  logic       digit_ready,
    output logic       key_active,
    output logic       overrun,
    input  logic       ovr_clr
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // The entry sample counts as the first stable one, so the last step is one short
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

`ifdef KEY_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt, rpt_nxt;
    logic             rpt_first, rpt_first_nxt;
`endif

    logic [9:0]       sync1, sync2;
    logic             any;
    logic [3:0]       code;
    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       cand, cand_nxt;
    logic             emit;

    // Two-flop synchroniser on every keypad line; idle lines read high
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 10'h3FF;
            sync2 <= 10'h3FF;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Priority encoder: ascending scan so the highest pressed key is the last written
    always_comb begin
        any  = ~&sync2;
        code = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (!sync2[i]) code = 4'(i);
        end
    end

    // Debounce FSM next-state and event generation
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cand_nxt  = cand;
        emit      = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rpt_nxt       = '0;
        rpt_first_nxt = 1'b1;
`endif
        case (state)
            ST_IDLE: begin
                if (any) begin
                    state_nxt = ST_DEBOUNCE;
                    cnt_nxt   = CNT_ONE;
                    cand_nxt  = code;
                end
            end
            ST_DEBOUNCE: begin
                if (!any) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (code != cand) begin
                    cand_nxt = code;
                    cnt_nxt  = CNT_ONE;
                end else if (cnt >= CNT_LAST) begin
                    state_nxt = ST_HELD;
                    cnt_nxt   = '0;
                    emit      = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!any) begin
                    state_nxt = ST_RELEASE;
                    cnt_nxt   = CNT_ONE;
                end
`ifdef KEY_AUTOREPEAT_EN
                else begin
                    rpt_first_nxt = rpt_first;
                    if (rpt >= (rpt_first ? RPT_DELAY_LAST : RPT_PERIOD_LAST)) begin
                        emit          = 1'b1;
                        rpt_nxt       = '0;
                        rpt_first_nxt = 1'b0;
                    end else begin
                        rpt_nxt = rpt + RPT_W'(1);
                    end
                end
`endif
            end
            default: begin
                if (any) begin
                    // Release bounce: back to held without a new event
                    state_nxt = ST_HELD;
                    cnt_nxt   = '0;
                end else if (cnt >= CNT_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
        endcase
    end

    // FSM state, digit register, handshake and sticky overrun
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cand        <= 4'd0;
            digit_bcd   <= 4'd0;
            digit_valid <= 1'b0;
            overrun     <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rpt         <= '0;
            rpt_first   <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            cand  <= cand_nxt;
`ifdef KEY_AUTOREPEAT_EN
            rpt       <= rpt_nxt;
            rpt_first <= rpt_first_nxt;
`endif
            if (emit && (!digit_valid || digit_ready)) begin
                digit_bcd   <= cand;
                digit_valid <= 1'b1;
            end else if (digit_valid && digit_ready) begin
                digit_valid <= 1'b0;
            end
            // A drop in the same cycle as a clear keeps the flag set
            overrun <= (overrun & ~ovr_clr) | (emit & digit_valid & ~digit_ready);
        end
    end

    assign key_active = (state == ST_HELD);

endmodule

// File: tb/tb_keypad_bcd_ctrl.sv
// tb/tb_keypad_bcd_ctrl.sv - table-driven bench for keypad_bcd_ctrl
module tb_keypad_bcd_ctrl;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] key_n;
    logic [3:0] digit_bcd;
    logic       digit_valid;
    logic       digit_ready;
    logic       key_active;
    logic       overrun;
    logic       ovr_clr;

    int n_checks = 0;
    int n_fail   = 0;
    int ev_times[$];
    logic [3:0] ev_bcd;

    typedef struct {
        logic [9:0] key;
        int         hold;
        logic [3:0] bcd;
        int         nev;
        int         lat;
        string      name;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    keypad_bcd_ctrl #(
`ifdef KEY_AUTOREPEAT_EN
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(8),
`endif
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_n(key_n),
        .digit_bcd(digit_bcd),
        .digit_valid(digit_valid),
        .digit_ready(digit_ready),
        .key_active(key_active),
        .overrun(overrun),
        .ovr_clr(ovr_clr)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int repeats(input int hold);
        int n = 0;
`ifdef KEY_AUTOREPEAT_EN
        for (int e = 26; e <= hold + 2; e += 8) n++;
`endif
        return n;
    endfunction

    task automatic press_raw(input logic [9:0] key, input int hold, input int tail);
        @(posedge clk);
        #1 key_n = key;
        repeat (hold) @(posedge clk);
        #1 key_n = 10'h3FF;
        repeat (tail) @(posedge clk);
        #1;
    endtask

    task automatic run_press(input logic [9:0] key, input int hold, input logic [3:0] bcd,
                             input int nev, input int lat, input string name);
        ev_times.delete();
        ev_bcd = 4'd0;
        @(posedge clk);
        #1 key_n = key;
        for (int cyc = 1; cyc <= hold + 14; cyc++) begin
            @(posedge clk);
            #1;
            if (digit_valid) begin
                ev_times.push_back(cyc);
                if (ev_times.size() == 1) ev_bcd = digit_bcd;
            end
            if (cyc == hold) begin
                check({name, "_key_active_held"}, int'(key_active), int'(nev > 0));
                key_n = 10'h3FF;
            end
        end
        check({name, "_events"}, ev_times.size(), nev);
        if (nev > 0 && ev_times.size() > 0) begin
            check({name, "_latency"}, ev_times[0], lat);
            check({name, "_bcd"}, int'(ev_bcd), int'(bcd));
        end
        check({name, "_key_active_released"}, int'(key_active), 0);
        check({name, "_valid_idle"}, int'(digit_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_t[5];
        vecs[0] = '{10'h37F, 30, 4'd7, 1, 6, "key7"};
        vecs[1] = '{10'h2F7, 12, 4'd8, 1, 6, "keys8_3"};
        vecs[2] = '{10'h3DF,  3, 4'd0, 0, 0, "key5_short"};
        vecs[3] = '{10'h3FE, 10, 4'd0, 1, 6, "key0"};
        vecs[4] = '{10'h1FF, 10, 4'd9, 1, 6, "key9"};
        vecs[5] = '{10'h000, 10, 4'd9, 1, 6, "all_keys"};

        rst_n = 1'b0;
        key_n = 10'h3FF;
        digit_ready = 1'b1;
        ovr_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", int'(digit_valid), 0);
        check("rst_bcd", int'(digit_bcd), 0);
        check("rst_key_active", int'(key_active), 0);
        check("rst_overrun", int'(overrun), 0);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_press(vecs[v].key, vecs[v].hold, vecs[v].bcd,
                      (vecs[v].nev > 0) ? vecs[v].nev + repeats(vecs[v].hold) : 0,
                      vecs[v].lat, vecs[v].name);
        end

        // Long hold of key 1: single event, or the auto-repeat train when enabled
        run_press(10'h3FD, 50, 4'd1, 1 + repeats(50), 6, "key1_long");
`ifdef KEY_AUTOREPEAT_EN
        exp_t = '{6, 26, 34, 42, 50};
        for (int i = 0; i < 5; i++) begin
            if (i < ev_times.size()) check("repeat_time", ev_times[i], exp_t[i]);
        end
`else
        exp_t = '{6, 0, 0, 0, 0};
        if (ev_times.size() > 0) check("single_time", ev_times[0], exp_t[0]);
`endif

        // Consumer stalled: second press dropped, first digit held, overrun sticky
        digit_ready = 1'b0;
        press_raw(10'h3FB, 8, 14);
        check("ovr_first_valid", int'(digit_valid), 1);
        check("ovr_first_bcd", int'(digit_bcd), 2);
        check("ovr_not_yet", int'(overrun), 0);
        press_raw(10'h1FF, 8, 14);
        check("ovr_hold_valid", int'(digit_valid), 1);
        check("ovr_hold_bcd", int'(digit_bcd), 2);
        check("ovr_set", int'(overrun), 1);
        digit_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_accept_valid", int'(digit_valid), 0);
        check("ovr_sticky", int'(overrun), 1);
        ovr_clr = 1'b1;
        @(posedge clk);
        #1 ovr_clr = 1'b0;
        check("ovr_cleared", int'(overrun), 0);

        // Drop and clear on the same edge: the set must win
        digit_ready = 1'b0;
        press_raw(10'h3F7, 8, 14);
        check("sw_first_bcd", int'(digit_bcd), 3);
        key_n = 10'h3BF;
        ovr_clr = 1'b1;
        repeat (6) @(posedge clk);
        #1 ovr_clr = 1'b0;
        check("sw_set_wins", int'(overrun), 1);
        check("sw_bcd_held", int'(digit_bcd), 3);
        repeat (4) @(posedge clk);
        #1 key_n = 10'h3FF;
        repeat (12) @(posedge clk);
        #1 digit_ready = 1'b1;
        @(posedge clk);
        #1 ovr_clr = 1'b1;
        @(posedge clk);
        #1 ovr_clr = 1'b0;
        check("sw_valid_drained", int'(digit_valid), 0);
        check("sw_cleared", int'(overrun), 0);

        // Reset in the middle of debouncing key 4
        @(posedge clk);
        #1 key_n = 10'h3EF;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        key_n = 10'h3FF;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("mid_rst_valid", int'(digit_valid), 0);
        check("mid_rst_bcd", int'(digit_bcd), 0);
        check("mid_rst_key_active", int'(key_active), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (digit_valid) check("mid_rst_no_event", 1, 0);
        end
        run_press(10'h3EF, 10, 4'd4, 1, 6, "key4_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
